// File: rtl/vga_timing_gen_pkg.sv
// Shared timing types, mode presets and elaboration helpers for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        logic [10:0] h_front;
        logic [10:0] h_sync;
        logic [10:0] h_back;
        logic [10:0] h_act;
        logic [10:0] v_front;
        logic [10:0] v_sync;
        logic [10:0] v_back;
        logic [10:0] v_act;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_front: 11'd16, h_sync: 11'd96,  h_back: 11'd48, h_act: 11'd640,
        v_front: 11'd10, v_sync: 11'd2,   v_back: 11'd33, v_act: 11'd480
    };

    localparam vga_mode_t MODE_800X600_72 = '{
        h_front: 11'd56, h_sync: 11'd120, h_back: 11'd64, h_act: 11'd800,
        v_front: 11'd37, v_sync: 11'd6,   v_back: 11'd23, v_act: 11'd600
    };

    // Derived constants for the default 640x480 mode.
    localparam int H_BLANK = int'(MODE_640X480_60.h_front) + int'(MODE_640X480_60.h_sync)
                           + int'(MODE_640X480_60.h_back);
    localparam int H_TOTAL = H_BLANK + int'(MODE_640X480_60.h_act);
    localparam int V_BLANK = int'(MODE_640X480_60.v_front) + int'(MODE_640X480_60.v_sync)
                           + int'(MODE_640X480_60.v_back);
    localparam int V_TOTAL = V_BLANK + int'(MODE_640X480_60.v_act);

    function automatic int clog2(input longint value);
        int     result;
        longint rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay.sv
// Enabled shift register used to align sync/active flags with frame-buffer read latency.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iEnable,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign oData = iData;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];
            logic [WIDTH-1:0] w_next  [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
                if (gi == 0) begin : g_head
                    assign w_next[gi] = iData;
                end else begin : g_body
                    assign w_next[gi] = r_stage[gi-1];
                end
            end

            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    r_stage <= '{default: '0};
                end else if (iEnable) begin
                    r_stage <= w_next;
                end
            end

            assign oData = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/blank generator with frame-buffer fetch requests and
// sync/blank/colour outputs aligned to the configured read latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACT      = 640,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_ACT      = 480,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_W    = 10,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 22
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEnable,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [ADDR_W-1:0]  oAddress,
    output logic [10:0]        oCurrent_X,
    output logic [10:0]        oCurrent_Y,
    output logic               oFrame_Start,
    output logic               oLine_Start,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_CLOCK
);

    localparam int L_H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int L_H_TOTAL = L_H_BLANK + H_ACT;
    localparam int L_V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int L_V_TOTAL = L_V_BLANK + V_ACT;

    localparam logic [10:0] C_H_BLANK    = 11'(L_H_BLANK);
    localparam logic [10:0] C_H_LAST     = 11'(L_H_TOTAL - 1);
    localparam logic [10:0] C_H_SYNC_BEG = 11'(H_FRONT);
    localparam logic [10:0] C_H_SYNC_END = 11'(H_FRONT + H_SYNC);
    localparam logic [10:0] C_V_BLANK    = 11'(L_V_BLANK);
    localparam logic [10:0] C_V_LAST     = 11'(L_V_TOTAL - 1);
    localparam logic [10:0] C_V_SYNC_BEG = 11'(V_FRONT);
    localparam logic [10:0] C_V_SYNC_END = 11'(V_FRONT + V_SYNC);

    generate
        if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || H_ACT < 1 ||
            V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || V_ACT < 1) begin : g_bad_timing
            $error("vga_timing_gen: every timing parameter must be at least 1");
        end
        if (L_H_TOTAL >= 2048 || L_V_TOTAL >= 2048) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must be below 2048");
        end
        if (RD_LATENCY < 0 || RD_LATENCY > 8) begin : g_bad_latency
            $error("vga_timing_gen: RD_LATENCY must be within 0..8");
        end
        if (clog2(longint'(H_ACT) * longint'(V_ACT)) > ADDR_W) begin : g_bad_addr
            $error("vga_timing_gen: ADDR_W too narrow for H_ACT*V_ACT");
        end
    endgenerate

    logic [10:0]        r_h_cont;
    logic [10:0]        r_v_cont;
    logic [ADDR_W-1:0]  r_addr;
    logic               w_active;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic [2:0]         w_flags_d;
    logic               r_vga_hs;
    logic               r_vga_vs;
    logic               r_vga_blank;
    logic [COLOR_W-1:0] r_vga_r;
    logic [COLOR_W-1:0] r_vga_g;
    logic [COLOR_W-1:0] r_vga_b;

    // Single-domain counters: V steps on the last pixel of a line, never from HS.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_h_cont <= '0;
            r_v_cont <= '0;
        end else if (iEnable) begin
            if (r_h_cont == C_H_LAST) begin
                r_h_cont <= '0;
                r_v_cont <= (r_v_cont == C_V_LAST) ? 11'd0 : r_v_cont + 11'd1;
            end else begin
                r_h_cont <= r_h_cont + 11'd1;
            end
        end
    end

    assign w_active     = (r_h_cont >= C_H_BLANK) && (r_v_cont >= C_V_BLANK);
    assign w_hs_raw     = (r_h_cont >= C_H_SYNC_BEG) && (r_h_cont < C_H_SYNC_END);
    assign w_vs_raw     = (r_v_cont >= C_V_SYNC_BEG) && (r_v_cont < C_V_SYNC_END);
    assign oRequest     = w_active && iEnable;
    assign oCurrent_X   = w_active ? (r_h_cont - C_H_BLANK) : 11'd0;
    assign oCurrent_Y   = w_active ? (r_v_cont - C_V_BLANK) : 11'd0;
    assign oFrame_Start = (r_h_cont == 11'd0) && (r_v_cont == 11'd0) && iEnable;
    assign oLine_Start  = (r_h_cont == 11'd0) && iEnable;
    assign oAddress     = r_addr;

    // Raster-order address tracks Y*H_ACT+X without a multiplier.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_addr <= '0;
        end else if (oFrame_Start) begin
            r_addr <= '0;
        end else if (oRequest) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (RD_LATENCY)
    ) u_align (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iEnable (iEnable),
        .iData   ({w_hs_raw, w_vs_raw, w_active}),
        .oData   (w_flags_d)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_vga_hs    <= ~HS_POL;
            r_vga_vs    <= ~VS_POL;
            r_vga_blank <= 1'b0;
            r_vga_r     <= '0;
            r_vga_g     <= '0;
            r_vga_b     <= '0;
        end else if (iEnable) begin
            r_vga_hs    <= w_flags_d[2] ? HS_POL : ~HS_POL;
            r_vga_vs    <= w_flags_d[1] ? VS_POL : ~VS_POL;
            r_vga_blank <= w_flags_d[0];
            r_vga_r     <= w_flags_d[0] ? iRed   : '0;
            r_vga_g     <= w_flags_d[0] ? iGreen : '0;
            r_vga_b     <= w_flags_d[0] ? iBlue  : '0;
        end
    end

    assign oVGA_HS    = r_vga_hs;
    assign oVGA_VS    = r_vga_vs;
    assign oVGA_BLANK = r_vga_blank;
    assign oVGA_R     = r_vga_r;
    assign oVGA_G     = r_vga_g;
    assign oVGA_B     = r_vga_b;
    assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 10x6 raster, active-low and active-high sync instances.
module tb_vga_timing_gen;

    localparam int HF = 2, HSW = 3, HBP = 1, HA = 4;
    localparam int VF = 1, VSW = 1, VBP = 1, VA = 3;
    localparam int HBL = HF + HSW + HBP;
    localparam int HT  = HBL + HA;
    localparam int VBL = VF + VSW + VBP;
    localparam int VT  = VBL + VA;
    localparam int CW  = 10;
    localparam int AW  = 22;
    localparam int LAT = 2;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iEnable = 1'b0;
    logic [CW-1:0] iRed = '0, iGreen = '0, iBlue = '0;

    logic          oRequest, oFrame_Start, oLine_Start;
    logic [AW-1:0] oAddress;
    logic [10:0]   oCurrent_X, oCurrent_Y;
    logic [CW-1:0] oVGA_R, oVGA_G, oVGA_B;
    logic          oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK;

    logic          p_request, p_frame_start, p_line_start;
    logic [AW-1:0] p_address;
    logic [10:0]   p_x, p_y;
    logic [CW-1:0] p_r, p_g, p_b;
    logic          p_hs, p_vs, p_blank, p_clock;

    always #5 iCLK = ~iCLK;

    vga_timing_gen #(
        .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP), .H_ACT(HA),
        .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .V_ACT(VA),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .RD_LATENCY(LAT), .ADDR_W(AW)
    ) u_dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oRequest(oRequest), .oAddress(oAddress),
        .oCurrent_X(oCurrent_X), .oCurrent_Y(oCurrent_Y),
        .oFrame_Start(oFrame_Start), .oLine_Start(oLine_Start),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK(oVGA_BLANK),
        .oVGA_CLOCK(oVGA_CLOCK)
    );

    vga_timing_gen #(
        .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP), .H_ACT(HA),
        .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .V_ACT(VA),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(CW), .RD_LATENCY(LAT), .ADDR_W(AW)
    ) u_dut_pos (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oRequest(p_request), .oAddress(p_address),
        .oCurrent_X(p_x), .oCurrent_Y(p_y),
        .oFrame_Start(p_frame_start), .oLine_Start(p_line_start),
        .oVGA_R(p_r), .oVGA_G(p_g), .oVGA_B(p_b),
        .oVGA_HS(p_hs), .oVGA_VS(p_vs), .oVGA_BLANK(p_blank),
        .oVGA_CLOCK(p_clock)
    );

    typedef struct {
        logic          hs_sync;
        logic          vs_sync;
        logic          blank;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          cur;
    bit            need_pop;
    int            mh, mv;
    logic [CW-1:0] hist1, hist2;
    int            n_tests = 0;
    int            n_fail = 0;
    int            fs_count = 0;
    int            cycle_no = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d, H=%0d V=%0d)",
                     tag, obs, exp, cycle_no, mh, mv);
        end
    endtask

    task automatic reset_model();
        exp_t idle;
        idle.hs_sync = 1'b0;
        idle.vs_sync = 1'b0;
        idle.blank   = 1'b0;
        idle.r = '0; idle.g = '0; idle.b = '0;
        mh = 0; mv = 0;
        hist1 = '0; hist2 = '0;
        sb_q.delete();
        // Aligned outputs stay idle until the first stage-0 value reaches the output register.
        for (int i = 0; i <= LAT; i++) sb_q.push_back(idle);
        need_pop = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_hs"},      oVGA_HS,      1);
        check_val({tag, "_vs"},      oVGA_VS,      1);
        check_val({tag, "_blank"},   oVGA_BLANK,   0);
        check_val({tag, "_r"},       oVGA_R,       0);
        check_val({tag, "_addr"},    oAddress,     0);
        check_val({tag, "_x"},       oCurrent_X,   0);
        check_val({tag, "_request"}, oRequest,     0);
        check_val({tag, "_frame"},   oFrame_Start, 0);
        check_val({tag, "_pos_hs"},  p_hs,         0);
        check_val({tag, "_pos_vs"},  p_vs,         0);
    endtask

    task automatic do_cycle(input bit en);
        exp_t e;
        bit   act, sync_h, sync_v;
        int   pix;
        iEnable = en;
        iRed    = hist2;
        iGreen  = hist2 + 10'd1;
        iBlue   = hist2 ^ 10'h155;
        #1;
        if (need_pop) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
            end else begin
                cur = sb_q.pop_front();
            end
            need_pop = 1'b0;
        end
        act    = (mh >= HBL) && (mv >= VBL);
        sync_h = (mh >= HF) && (mh < HF + HSW);
        sync_v = (mv >= VF) && (mv < VF + VSW);
        pix    = act ? (mv - VBL) * HA + (mh - HBL) : 0;

        check_val("request",     oRequest,     act && en);
        check_val("frame_start", oFrame_Start, (mh == 0) && (mv == 0) && en);
        check_val("line_start",  oLine_Start,  (mh == 0) && en);
        check_val("cur_x",       oCurrent_X,   act ? mh - HBL : 0);
        check_val("cur_y",       oCurrent_Y,   act ? mv - VBL : 0);
        if (act) check_val("address", oAddress, pix);
        check_val("hs",     oVGA_HS,    !cur.hs_sync);
        check_val("vs",     oVGA_VS,    !cur.vs_sync);
        check_val("blank",  oVGA_BLANK, cur.blank);
        check_val("red",    oVGA_R,     cur.r);
        check_val("green",  oVGA_G,     cur.g);
        check_val("blue",   oVGA_B,     cur.b);
        check_val("pos_hs", p_hs,       cur.hs_sync);
        check_val("pos_vs", p_vs,       cur.vs_sync);

        if (oFrame_Start) begin
            fs_count++;
            $display("[TB] frame start at cycle %0d", cycle_no);
        end

        if (en) begin
            e.hs_sync = sync_h;
            e.vs_sync = sync_v;
            e.blank   = act;
            e.r       = act ? CW'(pix)               : '0;
            e.g       = act ? CW'(pix + 1)           : '0;
            e.b       = act ? (CW'(pix) ^ 10'h155)   : '0;
            sb_q.push_back(e);
            need_pop = 1'b1;
            hist2 = hist1;
            hist1 = oAddress[CW-1:0];
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        cycle_no++;
        @(negedge iCLK);
    endtask

    initial begin
        reset_model();
        iRST_N  = 1'b0;
        iEnable = 1'b0;
        repeat (2) @(negedge iCLK);
        #1;
        check_reset_state("por");
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Full rate: frames start at cycles 0, 60 and 120.
        for (int i = 0; i < 130; i++) do_cycle(1'b1);
        check_val("frames_full_rate", fs_count, 3);

        // Half rate: 120 enabled cycles span two frame starts, each pulsed once.
        fs_count = 0;
        for (int i = 0; i < 240; i++) do_cycle(i % 2 == 1);
        check_val("frames_half_rate", fs_count, 2);

        for (int i = 0; i < HT * VT && !(mh == 7 && mv == 4); i++) do_cycle(1'b1);
        iEnable = 1'b0;
        iRST_N  = 1'b0;
        #1;
        check_reset_state("mid_frame");
        @(negedge iCLK);
        reset_model();
        iRST_N   = 1'b1;
        fs_count = 0;
        for (int i = 0; i < 70; i++) do_cycle(1'b1);
        check_val("frames_after_reset", fs_count, 2);

        for (int i = 0; i < 200; i++) do_cycle(1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
